// File: rtl/i2c_pkg.sv
// Shared types for the I2C byte transmitter:
// FSM states, quarter-phase codes, bit-index width.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_ACK,
    ST_HOLD,
    ST_STOP
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int BIT_W = 3;
  typedef logic [BIT_W-1:0] bit_idx_t;

endpackage

// File: rtl/i2c_qtick.sv
// SCL quarter-period timer: down-counter that
// ticks at zero and reloads on tick or restart.
module i2c_qtick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (restart || tick) cnt_d = RELOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_byte_tx.sv
// I2C master byte transmitter: START, MSB-first data,
// ACK sampling, then STOP or bus hold for the next byte.
module i2c_byte_tx
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       scl,
  output logic       sda_o,
  input  logic       sda_i,
  output logic       byte_done,
  output logic       ack_err,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  bit_idx_t   bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic       ack_smp_q, ack_smp_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic       tx_ready_q, tx_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic tick;
  logic restart;
  logic accept;

  i2c_qtick #(
    .CLK_DIV (CLK_DIV)
  ) u_qtick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    data_d    = data_q;
    last_d    = last_q;
    ack_smp_d = ack_smp_q;
    scl_d     = scl_q;
    sda_d     = sda_q;
    done_d    = 1'b0;
    err_d     = err_q;
    accept    = tx_valid && tx_ready_q;

    unique case (state_q)
      ST_IDLE: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        if (accept) begin
          data_d  = tx_data;
          last_d  = tx_last;
          state_d = ST_START;
          phase_d = Q0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (phase_q == Q0) begin
            sda_d   = 1'b0;
            phase_d = Q1;
          end else begin
            scl_d   = 1'b0;
            state_d = ST_DATA;
            phase_d = Q0;
            bit_d   = bit_idx_t'(7);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          unique case (phase_q)
            Q0: sda_d = data_q[bit_q];
            Q1: scl_d = 1'b1;
            Q2: begin end
            Q3: begin
              scl_d = 1'b0;
              if (bit_q == '0) state_d = ST_ACK;
              else             bit_d   = bit_q - bit_idx_t'(1);
            end
          endcase
        end
      end
      ST_ACK: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          unique case (phase_q)
            Q0: sda_d     = 1'b1;
            Q1: scl_d     = 1'b1;
            Q2: ack_smp_d = sda_i;
            Q3: begin
              scl_d   = 1'b0;
              done_d  = 1'b1;
              err_d   = ack_smp_q;
              state_d = (ack_smp_q || last_q) ? ST_STOP : ST_HOLD;
            end
          endcase
        end
      end
      ST_HOLD: begin
        // bus parked with scl low; next byte continues without START
        if (accept) begin
          data_d  = tx_data;
          last_d  = tx_last;
          state_d = ST_DATA;
          phase_d = Q0;
          bit_d   = bit_idx_t'(7);
        end
      end
      ST_STOP: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          unique case (phase_q)
            Q0: sda_d = 1'b0;
            Q1: scl_d = 1'b1;
            default: begin
              sda_d   = 1'b1;
              state_d = ST_IDLE;
              phase_d = Q0;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tx_ready_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
    busy_d     = (state_d != ST_IDLE);
    restart    = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= Q0;
      bit_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      ack_smp_q  <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      last_q     <= last_d;
      ack_smp_q  <= ack_smp_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign tx_ready  = tx_ready_q;
  assign scl       = scl_q;
  assign sda_o     = sda_q;
  assign byte_done = done_q;
  assign ack_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_byte_tx.sv
// Directed bench for i2c_byte_tx: one instance at
// CLK_DIV=1 for protocol cases, one at CLK_DIV=4 for timing.
module tb_i2c_byte_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       tx_valid1, tx_ready1, tx_last1;
  logic [7:0] tx_data1;
  logic       scl1, sda1, sda_i1, done1, err1, busy1;

  logic       tx_valid4, tx_ready4, tx_last4;
  logic [7:0] tx_data4;
  logic       scl4, sda4, sda_i4, done4, err4, busy4;

  i2c_byte_tx #(.CLK_DIV(1)) u1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid  (tx_valid1),
    .tx_ready  (tx_ready1),
    .tx_data   (tx_data1),
    .tx_last   (tx_last1),
    .scl       (scl1),
    .sda_o     (sda1),
    .sda_i     (sda_i1),
    .byte_done (done1),
    .ack_err   (err1),
    .busy      (busy1)
  );

  i2c_byte_tx #(.CLK_DIV(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid  (tx_valid4),
    .tx_ready  (tx_ready4),
    .tx_data   (tx_data4),
    .tx_last   (tx_last4),
    .scl       (scl4),
    .sda_o     (sda4),
    .sda_i     (sda_i4),
    .byte_done (done4),
    .ack_err   (err4),
    .busy      (busy4)
  );

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int acc1   = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_valid1 && tx_ready1) acc1 <= acc1 + 1;
  end

  // CLK_DIV=1 bus monitor
  logic        ps1 = 1'b1, pd1 = 1'b1, e1 = 1'b0;
  int          st1 = 0, sp1 = 0, dn1 = 0;
  logic [31:0] rs1 = '0;

  always @(negedge clk) begin
    if (ps1 && scl1 && pd1 && !sda1) st1 <= st1 + 1;
    if (ps1 && scl1 && !pd1 && sda1) sp1 <= sp1 + 1;
    if (!ps1 && scl1) rs1 <= {rs1[30:0], sda1};
    if (done1) begin
      dn1 <= dn1 + 1;
      e1  <= err1;
    end
    ps1 <= scl1;
    pd1 <= sda1;
  end

  // CLK_DIV=4 monitor: phase lengths and SDA stability
  logic        ps4 = 1'b1, pd4 = 1'b1, e4 = 1'b0;
  logic        trk4 = 1'b0, stt4 = 1'b0;
  int          len4 = 0, phn4 = 0, phb4 = 0;
  int          sdb4 = 0, sev4 = 0, dn4 = 0;
  logic [31:0] rs4 = '0;

  always @(negedge clk) begin
    if (!ps4 && scl4) rs4 <= {rs4[30:0], sda4};
    if (done4) begin
      dn4 <= dn4 + 1;
      e4  <= err4;
    end
    if (!busy4) trk4 <= 1'b0;
    else if (scl4 != ps4) begin
      if (trk4) begin
        phn4 <= phn4 + 1;
        if (len4 + 1 != 8) phb4 <= phb4 + 1;
      end
      trk4 <= 1'b1;
    end
    len4 <= (scl4 != ps4) ? 0 : len4 + 1;
    if (ps4 && scl4 && (pd4 != sda4)) begin
      if (sda4) begin
        if (busy4) sdb4 <= sdb4 + 1;
        else       sev4 <= sev4 + 1;
      end else if (!busy4 || stt4) begin
        sdb4 <= sdb4 + 1;
      end else begin
        sev4 <= sev4 + 1;
        stt4 <= 1'b1;
      end
    end
    if (!busy4) stt4 <= 1'b0;
    ps4 <= scl4;
    pd4 <= sda4;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // called at a negedge; t0 is the cycle count of the accept cycle
  task automatic send1(input logic [7:0] d, input logic last,
                       output int t0);
    int k;
    tx_data1  = d;
    tx_last1  = last;
    tx_valid1 = 1'b1;
    k = 0;
    while (!tx_ready1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", tx_ready1, 1);
    t0 = cyc;
    @(negedge clk);
    tx_valid1 = 1'b0;
  endtask

  task automatic wait_idle1(output int te);
    int k;
    k = 0;
    while (busy1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", busy1, 0);
    te = cyc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, te, k, r, hb, rb;
    int sb, pb, db, ab;
    logic p;

    rst_n     = 1'b0;
    tx_valid1 = 1'b0; tx_data1 = '0; tx_last1 = 1'b0; sda_i1 = 1'b0;
    tx_valid4 = 1'b0; tx_data4 = '0; tx_last4 = 1'b0; sda_i4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out1", {scl1, sda1, tx_ready1, busy1, done1, err1}, 6'b110000);
    chk("rst_out4", {scl4, sda4, tx_ready4, busy4, done4, err4}, 6'b110000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready1", tx_ready1, 1);
    chk("idle_ready4", tx_ready4, 1);

    // CLK_DIV=4: latency, phase widths, SDA stability
    tx_data4  = 8'hB2;
    tx_last4  = 1'b1;
    tx_valid4 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    tx_valid4 = 1'b0;
    chk("ready_drop4", tx_ready4, 0);
    k = 0;
    while (sda4 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("sda_latency4", cyc - t0, 5);
    k = 0;
    while (busy4 && k < 400) begin
      @(negedge clk);
      k++;
    end
    te = cyc;
    @(negedge clk);
    chk("busy_len4", te - t0, 165);
    chk("phase_cnt4", phn4, 19);
    chk("phase_bad4", phb4, 0);
    chk("sda_stable4", sdb4, 0);
    chk("start_stop4", sev4, 2);
    chk("bits4", rs4[9:0], {8'hB2, 2'b10});
    chk("done4", dn4, 1);
    chk("ackerr4", e4, 0);

    // single byte 0xA5 with STOP
    sb = st1; pb = sp1; db = dn1;
    send1(8'hA5, 1'b1, t0);
    wait_idle1(te);
    @(negedge clk);
    chk("a5_busy_len", te - t0, 42);
    chk("a5_bits", rs1[9:0], {8'hA5, 2'b10});
    chk("a5_done", dn1 - db, 1);
    chk("a5_ackerr", e1, 0);
    chk("a5_start", st1 - sb, 1);
    chk("a5_stop", sp1 - pb, 1);

    // two bytes with a 10-cycle gap in HOLD
    sb = st1; pb = sp1; db = dn1;
    send1(8'h3C, 1'b0, t0);
    k = 0;
    while (!done1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("hold_done", done1, 1);
    hb = 0;
    repeat (10) begin
      @(negedge clk);
      if (scl1 !== 1'b0 || tx_ready1 !== 1'b1 || busy1 !== 1'b1) hb++;
    end
    chk("hold_bus", hb, 0);
    send1(8'hFF, 1'b1, t0);
    wait_idle1(te);
    @(negedge clk);
    chk("two_bits", rs1[18:0], {8'h3C, 1'b1, 8'hFF, 2'b10});
    chk("two_start", st1 - sb, 1);
    chk("two_stop", sp1 - pb, 1);
    chk("two_done", dn1 - db, 2);
    chk("two_ackerr", e1, 0);

    // NACK forces STOP although tx_last=0
    sda_i1 = 1'b1;
    pb = sp1; db = dn1;
    send1(8'h55, 1'b0, t0);
    rb = 0;
    k = 0;
    while (busy1 && k < 200) begin
      if (tx_ready1) rb++;
      @(negedge clk);
      k++;
    end
    te = cyc;
    @(negedge clk);
    sda_i1 = 1'b0;
    chk("nack_busy_len", te - t0, 42);
    chk("nack_ready_low", rb, 0);
    chk("nack_ackerr", e1, 1);
    chk("nack_done", dn1 - db, 1);
    chk("nack_stop", sp1 - pb, 1);
    chk("nack_bits", rs1[9:0], {8'h55, 2'b10});

    // backpressure: tx_valid held, data changed after each accept
    ab = acc1;
    tx_data1  = 8'h96;
    tx_last1  = 1'b0;
    tx_valid1 = 1'b1;
    k = 0;
    while (tx_ready1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    tx_data1 = 8'h0F;
    tx_last1 = 1'b1;
    k = 0;
    while (!tx_ready1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    while (tx_ready1 && k < 210) begin
      @(negedge clk);
      k++;
    end
    tx_data1 = 8'hEE;
    tx_last1 = 1'b0;
    while (busy1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    tx_valid1 = 1'b0;
    chk("bp_idle", busy1, 0);
    @(negedge clk);
    chk("bp_accepts", acc1 - ab, 2);
    chk("bp_bits", rs1[18:0], {8'h96, 1'b1, 8'h0F, 2'b10});

    // asynchronous reset in DATA bit 3
    send1(8'h00, 1'b1, t0);
    r = 0;
    k = 0;
    p = scl1;
    while (r < 4 && k < 200) begin
      @(negedge clk);
      if (scl1 && !p) r++;
      p = scl1;
      k++;
    end
    while (scl1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_pos", {scl1, busy1}, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out", {scl1, sda1, busy1, tx_ready1, done1}, 5'b11000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", tx_ready1, 1);
    sb = st1; pb = sp1; db = dn1;
    send1(8'h01, 1'b1, t0);
    wait_idle1(te);
    @(negedge clk);
    chk("post_rst_len", te - t0, 42);
    chk("post_rst_bits", rs1[9:0], {8'h01, 2'b10});
    chk("post_rst_done", dn1 - db, 1);
    chk("post_rst_err", e1, 0);
    chk("post_rst_ss", {st1 - sb, sp1 - pb}, {32'd1, 32'd1});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
